// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit: FSM states, RV32I size/sign
// codes, byte-lane masks and small decode helpers.
package lsu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_DONE = 2'd3
  } lsu_state_e;

  localparam logic [2:0] F3_B  = 3'd0;
  localparam logic [2:0] F3_H  = 3'd1;
  localparam logic [2:0] F3_W  = 3'd2;
  localparam logic [2:0] F3_BU = 3'd4;
  localparam logic [2:0] F3_HU = 3'd5;

  localparam logic [3:0] MASK_B = 4'b0001;
  localparam logic [3:0] MASK_H = 4'b0011;
  localparam logic [3:0] MASK_W = 4'b1111;

  // Stores have no unsigned variants, so funct3 4/5 are only legal for loads.
  function automatic logic f3_legal(input logic [2:0] f3, input logic is_store);
    case (f3)
      F3_B, F3_H, F3_W: f3_legal = 1'b1;
      F3_BU, F3_HU:     f3_legal = ~is_store;
      default:          f3_legal = 1'b0;
    endcase
  endfunction

  // Byte offset actually used for the lanes: halves drop addr[0], words use lane 0.
  function automatic logic [1:0] eff_off(input logic [2:0] f3, input logic [1:0] lo);
    case (f3[1:0])
      2'd0:    eff_off = lo;
      2'd1:    eff_off = {lo[1], 1'b0};
      default: eff_off = 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/lsu_mem_if.sv
// Memory-side request/accept/response bus of the load/store unit.
// Handshake: a request transfers on a cycle with mem_req && mem_ready; the
// master holds addr/wen/wdata/mask stable until then; mem_valid carries one load
// response word and is only meaningful after the load request was accepted.
interface lsu_mem_if #(
  parameter int ADDR_W = 32
);
  logic              mem_req;
  logic              mem_ready;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_wen;
  logic [31:0]       mem_wdata;
  logic [3:0]        mem_mask;
  logic              mem_valid;
  logic [31:0]       mem_rdata;

  modport master (
    output mem_req, mem_addr, mem_wen, mem_wdata, mem_mask,
    input  mem_ready, mem_valid, mem_rdata
  );

  modport slave (
    input  mem_req, mem_addr, mem_wen, mem_wdata, mem_mask,
    output mem_ready, mem_valid, mem_rdata
  );
endinterface

// File: rtl/lsu_align.sv
// Combinational lane logic: byte mask and store shift for a request, and
// load extract plus sign/zero extension for a response.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [1:0]  off,
  input  logic [2:0]  funct3,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [3:0]  mask,
  output logic [31:0] wdata_sh,
  output logic [31:0] rdata_ext
);
  logic [31:0] rdata_sh;
  logic        sgn;

  always_comb begin
    mask      = MASK_W;
    wdata_sh  = wdata;
    rdata_ext = 32'd0;
    rdata_sh  = rdata >> {off, 3'b000};
    sgn       = ~funct3[2];
    case (funct3[1:0])
      2'd0: begin
        mask      = MASK_B << off;
        wdata_sh  = {24'd0, wdata[7:0]} << {off, 3'b000};
        rdata_ext = {{24{sgn & rdata_sh[7]}}, rdata_sh[7:0]};
      end
      2'd1: begin
        mask      = MASK_H << off;
        wdata_sh  = {16'd0, wdata[15:0]} << {off, 3'b000};
        rdata_ext = {{16{sgn & rdata_sh[15]}}, rdata_sh[15:0]};
      end
      default: begin
        mask      = MASK_W;
        wdata_sh  = wdata;
        rdata_ext = rdata_sh;
      end
    endcase
  end
endmodule

// File: rtl/load_store_unit.sv
// Multi-cycle load/store unit: IDLE -> REQ -> (WAIT) -> DONE over lsu_mem_if.
// Optional `LSU_MISALIGN_TRAP_EN` traps misaligned half/word accesses at accept.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 0
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic              i_load,
  input  logic              i_store,
  input  logic [2:0]        i_funct3,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [31:0]       i_wdata,
  lsu_mem_if.master         mem,
  output logic              o_done,
  output logic [31:0]       o_rdata,
  output logic              o_trap,
  output logic              o_timeout,
  output lsu_state_e        o_dbg_state
);
  lsu_state_e        state_q, state_d;
  logic [31:0]       cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [1:0]        off_q, off_d;
  logic [2:0]        f3_q, f3_d;
  logic              load_q, load_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [3:0]        mask_q, mask_d;
  logic              trap_q, trap_d;
  logic              tmo_q, tmo_d;
  logic [31:0]       rdata_q, rdata_d;

  logic [1:0]  acc_off;
  logic [3:0]  req_mask;
  logic [31:0] req_wdata;
  logic [31:0] req_rdata_unused;
  logic [3:0]  rsp_mask_unused;
  logic [31:0] rsp_wdata_unused;
  logic [31:0] rsp_rdata;
  logic        misaligned;
  logic        bad_op;

  assign acc_off = eff_off(i_funct3, i_addr[1:0]);

`ifdef LSU_MISALIGN_TRAP_EN
  assign misaligned = ((i_funct3[1:0] == 2'd1) && i_addr[0]) ||
                      ((i_funct3[1:0] == 2'd2) && (i_addr[1:0] != 2'b00));
`else
  assign misaligned = 1'b0;
`endif

  // No operation kind at all is treated like both kinds: nothing sensible to issue.
  assign bad_op = (i_load == i_store) || !f3_legal(i_funct3, i_store) || misaligned;

  lsu_align u_req_align (
    .off       (acc_off),
    .funct3    (i_funct3),
    .wdata     (i_wdata),
    .rdata     (32'd0),
    .mask      (req_mask),
    .wdata_sh  (req_wdata),
    .rdata_ext (req_rdata_unused)
  );

  lsu_align u_rsp_align (
    .off       (off_q),
    .funct3    (f3_q),
    .wdata     (32'd0),
    .rdata     (mem.mem_rdata),
    .mask      (rsp_mask_unused),
    .wdata_sh  (rsp_wdata_unused),
    .rdata_ext (rsp_rdata)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= 32'd0;
      addr_q  <= '0;
      off_q   <= 2'b00;
      f3_q    <= 3'd0;
      load_q  <= 1'b0;
      wdata_q <= 32'd0;
      mask_q  <= 4'd0;
      trap_q  <= 1'b0;
      tmo_q   <= 1'b0;
      rdata_q <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      off_q   <= off_d;
      f3_q    <= f3_d;
      load_q  <= load_d;
      wdata_q <= wdata_d;
      mask_q  <= mask_d;
      trap_q  <= trap_d;
      tmo_q   <= tmo_d;
      rdata_q <= rdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    off_d   = off_q;
    f3_d    = f3_q;
    load_d  = load_q;
    wdata_d = wdata_q;
    mask_d  = mask_q;
    trap_d  = trap_q;
    tmo_d   = tmo_q;
    rdata_d = rdata_q;
    case (state_q)
      ST_IDLE: begin
        if (i_valid) begin
          addr_d  = {i_addr[ADDR_W-1:2], 2'b00};
          off_d   = acc_off;
          f3_d    = i_funct3;
          load_d  = i_load;
          wdata_d = req_wdata;
          mask_d  = req_mask;
          trap_d  = bad_op;
          tmo_d   = 1'b0;
          rdata_d = 32'd0;
          cnt_d   = 32'd0;
          state_d = bad_op ? ST_DONE : ST_REQ;
        end
      end
      ST_REQ: begin
        if (mem.mem_ready) begin
          cnt_d   = 32'd0;
          state_d = load_q ? ST_WAIT : ST_DONE;
        end
      end
      ST_WAIT: begin
        cnt_d = cnt_q + 32'd1;
        if (mem.mem_valid) begin
          rdata_d = rsp_rdata;
          state_d = ST_DONE;
        end else if ((TIMEOUT != 0) && (cnt_q == 32'(TIMEOUT - 1))) begin
          trap_d  = 1'b1;
          tmo_d   = 1'b1;
          state_d = ST_DONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    o_ready       = (state_q == ST_IDLE);
    mem.mem_req   = (state_q == ST_REQ);
    mem.mem_wen   = (state_q == ST_REQ) && !load_q;
    mem.mem_mask  = (state_q == ST_REQ) ? mask_q : 4'd0;
    mem.mem_addr  = addr_q;
    mem.mem_wdata = wdata_q;
    o_done        = (state_q == ST_DONE);
    o_trap        = (state_q == ST_DONE) && trap_q;
    o_timeout     = (state_q == ST_DONE) && tmo_q;
    o_rdata       = rdata_q;
    o_dbg_state   = state_q;
  end
endmodule

// File: tb/tb_load_store_unit.sv
// Directed plus small randomised bench for load_store_unit with a scoreboard of
// expected {trap, timeout, rdata} completions.
module tb_load_store_unit;
  import lsu_pkg::*;

  logic        clk;
  logic        rst;
  logic        i_valid;
  logic        o_ready;
  logic        i_load;
  logic        i_store;
  logic [2:0]  i_funct3;
  logic [31:0] i_addr;
  logic [31:0] i_wdata;
  logic        o_done;
  logic [31:0] o_rdata;
  logic        o_trap;
  logic        o_timeout;
  lsu_state_e  o_dbg_state;

  int n_checks;
  int n_errors;
  logic [33:0] exp_q[$];

  lsu_mem_if #(.ADDR_W(32)) mem ();

  load_store_unit #(.ADDR_W(32), .TIMEOUT(5)) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_valid     (i_valid),
    .o_ready     (o_ready),
    .i_load      (i_load),
    .i_store     (i_store),
    .i_funct3    (i_funct3),
    .i_addr      (i_addr),
    .i_wdata     (i_wdata),
    .mem         (mem.master),
    .o_done      (o_done),
    .o_rdata     (o_rdata),
    .o_trap      (o_trap),
    .o_timeout   (o_timeout),
    .o_dbg_state (o_dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // driver: present one operation for one cycle; returns in the cycle after accept
  task automatic issue(input logic ld, input logic st, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] wd);
    i_valid  = 1'b1;
    i_load   = ld;
    i_store  = st;
    i_funct3 = f3;
    i_addr   = addr;
    i_wdata  = wd;
    tick();
    i_valid  = 1'b0;
  endtask

  task automatic check_done(input string tag);
    logic [33:0] e;
    chk({tag, "_done"}, o_done, 1'b1);
    if (exp_q.size() == 0) begin
      chk({tag, "_sb_empty"}, 1'b1, 1'b0);
    end else begin
      e = exp_q.pop_front();
      chk({tag, "_result"}, {o_trap, o_timeout, o_rdata}, e);
    end
  endtask

  task automatic wait_done(input string tag, input int budget);
    int k;
    k = 0;
    while (!o_done && k < budget) begin
      tick();
      k++;
    end
    check_done(tag);
  endtask

  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [1:0] off,
                                             input logic [31:0] word);
    logic [7:0]  b;
    logic [15:0] h;
    b = word[8*off +: 8];
    h = off[1] ? word[31:16] : word[15:0];
    case (f3)
      3'd0:    return {{24{b[7]}}, b};
      3'd4:    return {24'd0, b};
      3'd1:    return {{16{h[15]}}, h};
      3'd5:    return {16'd0, h};
      default: return word;
    endcase
  endfunction

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst = 1'b1;
    i_valid = 1'b0; i_load = 1'b0; i_store = 1'b0; i_funct3 = 3'd0;
    i_addr = 32'd0; i_wdata = 32'd0;
    mem.mem_ready = 1'b0; mem.mem_valid = 1'b0; mem.mem_rdata = 32'd0;
    tick(); tick();
    rst = 1'b0;

    // reset state
    chk("rst_ready", o_ready, 1'b1);
    chk("rst_req", mem.mem_req, 1'b0);
    chk("rst_wen", mem.mem_wen, 1'b0);
    chk("rst_mask", mem.mem_mask, 4'd0);
    chk("rst_outs", {o_done, o_trap, o_timeout, o_rdata}, 35'd0);
    chk("rst_state", o_dbg_state, ST_IDLE);

    // SB 0x1003
    mem.mem_ready = 1'b1;
    issue(1'b0, 1'b1, 3'd0, 32'h1003, 32'h0000_00AB);
    exp_q.push_back({2'b00, 32'd0});
    chk("sb_req", {mem.mem_req, mem.mem_wen, o_ready, o_done}, 4'b1100);
    chk("sb_addr", mem.mem_addr, 32'h1000);
    chk("sb_mask", mem.mem_mask, 4'b1000);
    chk("sb_wdata", mem.mem_wdata, 32'hAB00_0000);
    tick();
    check_done("sb");
    tick();
    chk("sb_pulse", {o_done, o_ready}, 2'b01);

    // SH 0x6002
    issue(1'b0, 1'b1, 3'd1, 32'h6002, 32'h1234_5678);
    exp_q.push_back({2'b00, 32'd0});
    chk("sh_mask", mem.mem_mask, 4'b1100);
    chk("sh_wdata", mem.mem_wdata, 32'h5678_0000);
    tick();
    check_done("sh");
    tick();

    // LH / LHU 0x2002 with 3-cycle response delay
    for (int u = 0; u < 2; u++) begin
      issue(1'b1, 1'b0, (u == 0) ? 3'd1 : 3'd5, 32'h2002, 32'd0);
      exp_q.push_back({2'b00, (u == 0) ? 32'hFFFF_8001 : 32'h0000_8001});
      chk("lh_req", {mem.mem_req, mem.mem_wen}, 2'b10);
      chk("lh_mask", mem.mem_mask, 4'b1100);
      tick();
      chk("lh_wait", o_dbg_state, ST_WAIT);
      tick(); tick();
      chk("lh_stall", {o_ready, o_done}, 2'b00);
      mem.mem_valid = 1'b1; mem.mem_rdata = 32'h8001_1234;
      tick();
      mem.mem_valid = 1'b0; mem.mem_rdata = 32'd0;
      check_done((u == 0) ? "lh" : "lhu");
      tick();
    end

    // LW 0x3000 with memory stalling the request for 4 cycles
    mem.mem_ready = 1'b0;
    issue(1'b1, 1'b0, 3'd2, 32'h3000, 32'd0);
    exp_q.push_back({2'b00, 32'hDEAD_BEEF});
    for (int c = 0; c < 4; c++) begin
      chk("lw_stall_fields", {mem.mem_req, mem.mem_wen, mem.mem_mask, o_ready, o_done}, 8'b1011_1100);
      chk("lw_stall_addr", mem.mem_addr, 32'h3000);
      tick();
    end
    mem.mem_ready = 1'b1;
    chk("lw_stall_last", mem.mem_req, 1'b1);
    tick();
    mem.mem_valid = 1'b1; mem.mem_rdata = 32'hDEAD_BEEF;
    tick();
    mem.mem_valid = 1'b0;
    check_done("lw_stall");
    tick();
    chk("lw_single_done", o_done, 1'b0);

    // timeout: no response for 5 WAIT cycles, then a late response
    issue(1'b1, 1'b0, 3'd2, 32'h3004, 32'd0);
    exp_q.push_back({2'b11, 32'd0});
    tick();
    for (int c = 0; c < 5; c++) begin
      chk("tmo_wait", {o_dbg_state, o_done}, {ST_WAIT, 1'b0});
      tick();
    end
    check_done("tmo");
    mem.mem_valid = 1'b1; mem.mem_rdata = 32'h5555_AAAA;
    tick();
    chk("tmo_late", {o_ready, o_done, o_trap, o_rdata}, {3'b100, 32'd0});
    tick();
    mem.mem_valid = 1'b0;
    chk("tmo_late_idle", {o_dbg_state, o_done}, {ST_IDLE, 1'b0});

    // LW 0x4002 misaligned
`ifdef LSU_MISALIGN_TRAP_EN
    issue(1'b1, 1'b0, 3'd2, 32'h4002, 32'd0);
    exp_q.push_back({2'b10, 32'd0});
    chk("mis_noreq", mem.mem_req, 1'b0);
    check_done("mis_trap");
    tick();
    chk("mis_noreq_after", {mem.mem_req, o_ready}, 2'b01);
`else
    issue(1'b1, 1'b0, 3'd2, 32'h4002, 32'd0);
    exp_q.push_back({2'b00, 32'h1122_3344});
    chk("mis_req", {mem.mem_req, mem.mem_mask}, 5'b1_1111);
    chk("mis_addr", mem.mem_addr, 32'h4000);
    tick();
    mem.mem_valid = 1'b1; mem.mem_rdata = 32'h1122_3344;
    tick();
    mem.mem_valid = 1'b0;
    check_done("mis_load");
    tick();
`endif

    // reset while in WAIT
    issue(1'b1, 1'b0, 3'd2, 32'h7000, 32'd0);
    tick();
    chk("rstw_wait", o_dbg_state, ST_WAIT);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rstw_idle", {o_dbg_state, o_ready, mem.mem_req, mem.mem_wen, mem.mem_mask},
        {ST_IDLE, 1'b1, 1'b0, 1'b0, 4'd0});
    chk("rstw_outs", {o_done, o_trap, o_timeout, o_rdata}, 35'd0);

    // illegal operations trap at accept without a request
    issue(1'b1, 1'b0, 3'd3, 32'h8000, 32'd0);
    exp_q.push_back({2'b10, 32'd0});
    chk("f3_noreq", mem.mem_req, 1'b0);
    check_done("f3_trap");
    tick();
    issue(1'b1, 1'b1, 3'd2, 32'h8000, 32'd0);
    exp_q.push_back({2'b10, 32'd0});
    chk("both_noreq", mem.mem_req, 1'b0);
    check_done("both_trap");
    tick();
    issue(1'b0, 1'b1, 3'd4, 32'h8000, 32'd0);
    exp_q.push_back({2'b10, 32'd0});
    check_done("st_f3_trap");
    tick();

    // random aligned loads
    for (int r = 0; r < 8; r++) begin
      logic [2:0]  f3;
      logic [1:0]  off;
      logic [31:0] word;
      case ($urandom_range(0, 4))
        0: f3 = 3'd0;
        1: f3 = 3'd4;
        2: f3 = 3'd1;
        3: f3 = 3'd5;
        default: f3 = 3'd2;
      endcase
      off  = (f3[1:0] == 2'd0) ? 2'($urandom_range(0, 3)) :
             (f3[1:0] == 2'd1) ? {1'($urandom_range(0, 1)), 1'b0} : 2'b00;
      word = $urandom();
      issue(1'b1, 1'b0, f3, {28'h0000_500, 2'b00, off}, 32'd0);
      exp_q.push_back({2'b00, model_load(f3, off, word)});
      tick();
      mem.mem_valid = 1'b1; mem.mem_rdata = word;
      tick();
      mem.mem_valid = 1'b0;
      wait_done("rnd_load", 4);
      tick();
    end

    chk("sb_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule

// File: doc/load_store_unit.md
# load_store_unit

Multi-cycle load/store unit for the hart's memory stage. It replaces the single-cycle combinational dmem path with a request/accept/response memory handshake and adds a parametrised address width, an optional response timeout, and misalignment trapping. It handles byte/half/word masking, lane shifting, and sign/zero extension. It stalls the pipeline through `o_ready` while an access is outstanding.

## Interface
- `ADDR_W`, 32, byte-address width (data width fixed at 32).
- `TIMEOUT`, 0, maximum cycles spent waiting for a load response; 0 disables the timeout.

- `i_clk` in 1: clock.
- `i_rst` in 1: synchronous, active-high reset.
- `i_valid` in 1: execute stage presents a memory operation.
- `o_ready` out 1: unit accepts an operation this cycle (IDLE only).
- `i_load` / `i_store` in 1 each: operation kind; both high is illegal and traps.
- `i_funct3` in 3: RV32I size/sign code (LB=0, LH=1, LW=2, LBU=4, LHU=5; SB=0, SH=1, SW=2).
- `i_addr` in ADDR_W: effective byte address.
- `i_wdata` in 32: store data (rs2).
- `o_mem_req` out 1: request valid.
- `i_mem_ready` in 1: memory accepts request this cycle.
- `o_mem_addr` out ADDR_W: word-aligned address, low 2 bits zero.
- `o_mem_wen` out 1: request is a write.
- `o_mem_wdata` out 32: lane-shifted store data.
- `o_mem_mask` out 4: byte-lane mask.
- `i_mem_valid` in 1: load response valid.
- `i_mem_rdata` in 32: load response word.
- `o_done` out 1: one-cycle completion pulse.
- `o_rdata` out 32: aligned and extended load result (0 for stores and traps).
- `o_trap` out 1: access trapped; qualified by `o_done`.
- `o_timeout` out 1: trap cause was a timeout; qualified by `o_done`.

## Operation
- States: IDLE, REQ, WAIT, DONE.
- IDLE:
  - `o_ready`=1.
  - On `i_valid`, operands are captured.
  - An illegal funct3, or a load and store asserted together, goes to DONE with the trap flag set.
  - A misaligned access goes to DONE with the trap flag set (see Configuration).
  - Otherwise the unit moves to REQ.
- REQ:
  - `o_mem_req`=1. Address, wen, wdata and mask stay stable until `i_mem_ready`.
  - Accepted store: go to DONE.
  - Accepted load: go to WAIT.
- WAIT:
  - On `i_mem_valid`, register the extracted and extended result and go to DONE.
  - A cycle counter increments each WAIT cycle. If TIMEOUT≠0 and the counter reaches TIMEOUT without a response, go to DONE with trap and timeout set.
  - A response arriving after a timeout is ignored.
- DONE: `o_done`=1 for exactly one cycle, then IDLE.
- Mask and lane rules:
  - Byte: mask = 1<<addr[1:0]; wdata = wdata[7:0]<<(8·addr[1:0]).
  - Half: mask = 0b0011<<addr[1:0]; data shifted by 8·addr[1:0].
  - Word: mask = 0b1111.
  - Loads shift rdata right by 8·addr[1:0], then sign-extend (funct3[2]=0) or zero-extend.
- `i_valid` is ignored when `o_ready`=0. The execute stage holds its operation.

## Timing
- Reset: state IDLE, counter 0. `o_ready`=1. `o_mem_req`, `o_mem_wen`, `o_done`, `o_trap`, `o_timeout` = 0. `o_mem_mask`=0, `o_rdata`=0.
- Reset mid-operation abandons the access. The memory must tolerate a dropped request or response.
- Accept at edge N → REQ during N+1.
- Store with zero-wait memory: `o_done` in N+2.
- Load with zero-wait memory and response one cycle after accept: WAIT during N+2, `o_done` in N+3.
- `i_mem_valid` is only legal from the cycle after acceptance. It is ignored outside WAIT.
- Trap detected at accept: `o_done` in N+1, with no memory request issued.

## Configuration
- `LSU_MISALIGN_TRAP_EN` defined: a half access with addr[0]=1, or a word access with addr[1:0]≠0, traps at accept (DONE, `o_trap`=1, no request).
- Not defined: misalignment is not checked.
  - Half accesses use addr[1] only (addr[0] forced to 0).
  - Word accesses force addr[1:0]=0.
  - No trap is raised.

## Structure
- `lsu_pkg`: state enum, funct3 size/sign constants, mask constants.
- One combinational sub-module, `lsu_align`, produces mask, store lane shift and load extract/extend from addr[1:0] and funct3. It is instantiated once for requests and once for responses.
- FSM, counter and operand registers live in `load_store_unit`.

## Test plan
- SB, addr 0x1003, wdata 0x000000AB, `i_mem_ready`=1 → `o_mem_addr` 0x1000, mask 0b1000, wdata 0xAB000000, `o_done` two cycles after accept, `o_trap`=0.
- LH, addr 0x2002, response 0x8001xxxx after a 3-cycle delay → `o_rdata` 0xFFFF8001. LHU with the same stimulus → 0x00008001.
- LW, addr 0x3000, `i_mem_ready` held low 4 cycles → request fields stable throughout, `o_ready`=0, single `o_done`.
- TIMEOUT=5, LW with no response → `o_done` after 5 WAIT cycles, `o_trap`=1, `o_timeout`=1. A late `i_mem_valid` has no effect.
- LW, addr 0x4002:
  - With `LSU_MISALIGN_TRAP_EN`: trap at N+1 and `o_mem_req` never asserted.
  - Without it: request to 0x4000 with mask 0b1111.
- `i_rst` asserted in WAIT → next cycle IDLE, `o_ready`=1, all outputs at reset values. funct3=3 load → immediate trap.
